ps2_scan_decoder: RTL

- Consumes the raw byte stream from the PS/2 `keyboard` receiver (`scan_code`, `scan_ready`) and returns its `read` acknowledge. This replaces the separate oneshot.
- Assembles multi-byte Set-2 sequences (E0 extended, F0 break, E1 Pause) into single key events.
- Maintains held-flags for four tracked keys. Sits between the receiver and game/LED logic.

---
 rtl/ps2_scan_decoder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Turns the raw PS/2 Set-2 byte stream into single key events. Multi-byte
//   sequences (E0 extended, F0 break, E1 Pause) are assembled here. Held flags
//   are kept for four tracked keys.
//
//   Optional build macro: TYPEMATIC_FILTER_EN. When it is defined, auto-repeat
//   makes of the last pressed key are suppressed.
//
// Ports
//   clock50    in   system clock
//   reset      in   synchronous, active-high reset
//   scan_code  in   [7:0] receiver byte, valid while scan_ready is high
//   scan_ready in   receiver byte-available level
//   read       out  one-cycle acknowledge, in the cycle after the accept edge
//   ev_valid   out  one-cycle key-event strobe, one cycle after read
//   ev_code    out  [7:0] final byte of the event (held until the next event)
//   ev_ext     out  event carried E0
//   ev_break   out  event is a release
//   ev_pause   out  event is the Pause key (one cycle, together with ev_valid)
//   key_held   out  [3:0] bit i high while tracked key i is down
//   seq_error  out  one-cycle strobe when a sequence is abandoned
//
// Handshake: a byte is taken once, on the rising edge of scan_ready. read then
// acknowledges it for exactly one cycle, and scan_ready must fall before the
// next byte can be accepted.
module ps2_scan_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  KEY0_CODE      = 8'h1D,
  parameter logic [7:0]  KEY1_CODE      = 8'h1C,
  parameter logic [7:0]  KEY2_CODE      = 8'h1B,
  parameter logic [7:0]  KEY3_CODE      = 8'h23
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  output logic       read,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_pause,
  output logic [3:0] key_held,
  output logic       seq_error
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0] KEYS = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          acc_q, acc_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ev_valid_q, ev_valid_d;
  logic [7:0]    ev_code_q, ev_code_d;
  logic          ev_ext_q, ev_ext_d;
  logic          ev_break_q, ev_break_d;
  logic          ev_pause_q, ev_pause_d;
  logic [3:0]    key_held_q, key_held_d;
  logic          seq_error_q, seq_error_d;
`ifdef TYPEMATIC_FILTER_EN
  logic          last_vld_q, last_vld_d;
  logic          last_ext_q, last_ext_d;
  logic [7:0]    last_code_q, last_code_d;
`endif

  // Expected Pause bytes, indexed by position in the sequence.
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3: pause_byte = 8'hE1;
      3'd1, 3'd5: pause_byte = 8'h14;
      3'd2, 3'd7: pause_byte = 8'h77;
      default:    pause_byte = 8'hF0;
    endcase
  endfunction

  state_t st;
  logic   redo, do_ev, e_ext, e_brk, e_pause, suppress;

  always_comb begin
    rdy_d       = scan_ready;
    acc_d       = scan_ready & ~rdy_q;
    byte_d      = (scan_ready & ~rdy_q) ? scan_code : byte_q;
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    cnt_d       = '0;
    seq_error_d = 1'b0;
    ev_valid_d  = 1'b0;
    ev_pause_d  = 1'b0;
    ev_code_d   = ev_code_q;
    ev_ext_d    = ev_ext_q;
    ev_break_d  = ev_break_q;
    key_held_d  = key_held_q;
`ifdef TYPEMATIC_FILTER_EN
    last_vld_d  = last_vld_q;
    last_ext_d  = last_ext_q;
    last_code_d = last_code_q;
`endif
    st       = state_q;
    redo     = 1'b0;
    do_ev    = 1'b0;
    e_ext    = 1'b0;
    e_brk    = 1'b0;
    e_pause  = 1'b0;
    suppress = 1'b0;

    // Timeout is resolved first, so a byte arriving in the same cycle is
    // decoded from IDLE.
    if (state_q != S_IDLE) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        seq_error_d = 1'b1;
        st          = S_IDLE;
        state_d     = S_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (acc_q) begin
      cnt_d = '0;
      // 00/FF are keyboard error codes: they are acknowledged but ignored.
      if (byte_q != 8'h00 && byte_q != 8'hFF) begin
        case (st)
          S_IDLE: redo = 1'b1;
          S_E0: begin
            if (byte_q == 8'hF0)      state_d = S_E0F0;
            else if (byte_q == 8'hE0) state_d = S_E0;
            else if (byte_q == 8'hE1) begin state_d = S_PAUSE; pcnt_d = 3'd1; end
            else begin do_ev = 1'b1; e_ext = 1'b1; state_d = S_IDLE; end
          end
          S_F0: begin
            if (byte_q == 8'hF0 || byte_q == 8'hE0) begin seq_error_d = 1'b1; redo = 1'b1; end
            else begin do_ev = 1'b1; e_brk = 1'b1; state_d = S_IDLE; end
          end
          S_E0F0: begin
            if (byte_q == 8'hF0 || byte_q == 8'hE0 || byte_q == 8'hE1) begin
              seq_error_d = 1'b1;
              redo        = 1'b1;
            end else begin
              do_ev = 1'b1; e_ext = 1'b1; e_brk = 1'b1; state_d = S_IDLE;
            end
          end
          S_PAUSE: begin
            if (byte_q == pause_byte(pcnt_q)) begin
              if (pcnt_q == 3'd7) begin do_ev = 1'b1; e_pause = 1'b1; state_d = S_IDLE; end
              else pcnt_d = pcnt_q + 3'd1;
            end else begin
              seq_error_d = 1'b1;
              redo        = 1'b1;
            end
          end
          default: redo = 1'b1;
        endcase

        // Fresh decode from IDLE: also used to restart after a bad sequence.
        if (redo) begin
          case (byte_q)
            8'hE0:   state_d = S_E0;
            8'hF0:   state_d = S_F0;
            8'hE1:   begin state_d = S_PAUSE; pcnt_d = 3'd1; end
            default: begin do_ev = 1'b1; state_d = S_IDLE; end
          endcase
        end
      end
    end

    if (do_ev) begin
      if (e_pause) begin
        ev_valid_d = 1'b1;
        ev_pause_d = 1'b1;
        ev_code_d  = 8'h77;
        ev_ext_d   = 1'b0;
        ev_break_d = 1'b0;
      end else begin
`ifdef TYPEMATIC_FILTER_EN
        if (last_vld_q && last_ext_q == e_ext && last_code_q == byte_q) begin
          if (e_brk) last_vld_d = 1'b0;
          else       suppress   = 1'b1;
        end else if (!e_brk) begin
          last_vld_d  = 1'b1;
          last_ext_d  = e_ext;
          last_code_d = byte_q;
        end
`endif
        if (!suppress) begin
          ev_valid_d = 1'b1;
          ev_code_d  = byte_q;
          ev_ext_d   = e_ext;
          ev_break_d = e_brk;
          for (int i = 0; i < 4; i++) begin
            if (!e_ext && byte_q == KEYS[i*8 +: 8]) key_held_d[i] = ~e_brk;
          end
        end
      end
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      // Track the level so a byte already present at reset is not re-taken.
      rdy_q       <= scan_ready;
      acc_q       <= 1'b0;
      byte_q      <= 8'h00;
      state_q     <= S_IDLE;
      pcnt_q      <= 3'd0;
      cnt_q       <= '0;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_pause_q  <= 1'b0;
      key_held_q  <= 4'h0;
      seq_error_q <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= 8'h00;
`endif
    end else begin
      rdy_q       <= rdy_d;
      acc_q       <= acc_d;
      byte_q      <= byte_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      cnt_q       <= cnt_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_ext_q    <= ev_ext_d;
      ev_break_q  <= ev_break_d;
      ev_pause_q  <= ev_pause_d;
      key_held_q  <= key_held_d;
      seq_error_q <= seq_error_d;
`ifdef TYPEMATIC_FILTER_EN
      last_vld_q  <= last_vld_d;
      last_ext_q  <= last_ext_d;
      last_code_q <= last_code_d;
`endif
    end
  end

  assign read      = acc_q;
  assign ev_valid  = ev_valid_q;
  assign ev_code   = ev_code_q;
  assign ev_ext    = ev_ext_q;
  assign ev_break  = ev_break_q;
  assign ev_pause  = ev_pause_q;
  assign key_held  = key_held_q;
  assign seq_error = seq_error_q;

endmodule
